// File: rtl/comp_event_monitor.sv
// comp_event_monitor: qualifies comparator g/l/e results, tallies outcomes, raises a hysteresis-filtered sustained-greater alarm
module comp_event_monitor #(
    parameter int CNT_W   = 8,
    parameter int RUN_LEN = 4,
    parameter int HYST    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             g,
    input  logic             l,
    input  logic             e,
    output logic [CNT_W-1:0] g_cnt,
    output logic [CNT_W-1:0] l_cnt,
    output logic [CNT_W-1:0] e_cnt,
    output logic [3:0]       run_len,
    output logic             alarm,
    output logic             err
);
    // ALARM and RELEASE share the top bit so alarm is simply state[1]
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COUNT   = 2'd1;
    localparam logic [1:0] ALARM   = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;
    localparam logic [3:0] RUN_L   = 4'(RUN_LEN);
    localparam logic [3:0] HYST_L  = 4'(HYST);

    logic [1:0] state, state_nx;
    logic [3:0] rel, rel_nx, run_nx, rel_inc;
    logic       legal, smp, bad;

    // exactly-one-hot check: odd parity excluding the all-ones word
    always_comb begin
        legal   = (g ^ l ^ e) & ~(g & l & e);
        smp     = in_valid & legal;
        bad     = in_valid & ~legal;
        run_nx  = g ? (run_len == 4'hf ? run_len : run_len + 4'd1) : 4'd0;
        rel_inc = rel + 4'd1;
    end

    // next-state logic, only consulted on legal valid samples
    always_comb begin
        state_nx = state;
        rel_nx   = rel;
        case (state)
            IDLE:    state_nx = g ? COUNT : IDLE;
            COUNT:   state_nx = g ? (run_nx == RUN_L ? ALARM : COUNT) : IDLE;
            ALARM: begin
                state_nx = g ? ALARM : (HYST == 1 ? IDLE : RELEASE);
                rel_nx   = g || HYST == 1 ? 4'd0 : 4'd1;
            end
            default: begin
                state_nx = g ? ALARM : (rel_inc == HYST_L ? IDLE : RELEASE);
                rel_nx   = g || rel_inc == HYST_L ? 4'd0 : rel_inc;
            end
        endcase
    end

    // state, run length and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rel     <= 4'd0;
            run_len <= 4'd0;
            err     <= 1'b0;
        end else if (clr) begin
            state   <= IDLE;
            rel     <= 4'd0;
            run_len <= 4'd0;
            err     <= 1'b0;
        end else if (smp) begin
            state   <= state_nx;
            rel     <= rel_nx;
            run_len <= run_nx;
        end else if (bad) begin
            err     <= 1'b1;
        end
    end

    // saturating outcome tallies
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_cnt <= '0;
            l_cnt <= '0;
            e_cnt <= '0;
        end else if (clr) begin
            g_cnt <= '0;
            l_cnt <= '0;
            e_cnt <= '0;
        end else if (smp) begin
            g_cnt <= g && g_cnt != '1 ? g_cnt + CNT_W'(1) : g_cnt;
            l_cnt <= l && l_cnt != '1 ? l_cnt + CNT_W'(1) : l_cnt;
            e_cnt <= e && e_cnt != '1 ? e_cnt + CNT_W'(1) : e_cnt;
        end
    end

    assign alarm = state[1];
endmodule
